// File: rtl/bullet_pool_pkg.sv
// Shared constants and types for the bullet pool: direction encoding,
// default screen/spawn geometry and the per-slot state type.
package bullet_pool_pkg;

    // Direction field encoding used by dir_x / dir_y.
    localparam logic [1:0] DIR_POS = 2'b01;
    localparam logic [1:0] DIR_NEG = 2'b10;

    // Default playfield and spawn point.
    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;
    localparam int DEF_START_X  = 79;
    localparam int DEF_START_Y  = 59;

    typedef enum logic {
        SLOT_IDLE   = 1'b0,
        SLOT_FLYING = 1'b1
    } slot_state_t;

    // Map a 2-bit direction code to a signed step of -1, 0 or +1.
    function automatic logic signed [1:0] dir_to_delta(input logic [1:0] dir);
        case (dir)
            DIR_POS: return 2'sd1;
            DIR_NEG: return -2'sd1;
            default: return 2'sd0;
        endcase
    endfunction

endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: IDLE/FLYING state, position, latched direction and the
// screen-bounds check that retires the bullet when it would leave the field.
module bullet_slot
    import bullet_pool_pkg::*;
#(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int START_X  = DEF_START_X,
    parameter int START_Y  = DEF_START_Y
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           alloc,
    input  logic           tick,
    input  logic           hit,
    input  logic [1:0]     dir_x,
    input  logic [1:0]     dir_y,
    output logic           active,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y
);

    slot_state_t        state, state_nxt;
    logic [X_W-1:0]     x_nxt;
    logic [Y_W-1:0]     y_nxt;
    logic signed [1:0]  dx, dy, dx_nxt, dy_nxt;
    int                 nx, ny;
    logic               out_of_bounds;

    // Register the slot state, position and latched direction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SLOT_IDLE;
            x     <= '0;
            y     <= '0;
            dx    <= '0;
            dy    <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state <= state_nxt;
            x     <= x_nxt;
            y     <= y_nxt;
            dx    <= dx_nxt;
            dy    <= dy_nxt;
        end
    end

    // Next state: allocation spawns, hit retires, tick steps or retires.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latch).
        state_nxt     = state;
        x_nxt         = x;
        y_nxt         = y;
        dx_nxt        = dx;
        dy_nxt        = dy;
        nx            = int'(x) + int'(dx);
        ny            = int'(y) + int'(dy);
        out_of_bounds = (nx < 0) || (nx >= SCREEN_W) || (ny < 0) || (ny >= SCREEN_H);

        case (state)
            SLOT_IDLE: begin
                if (alloc) begin
                    state_nxt = SLOT_FLYING;
                    x_nxt     = X_W'(START_X);
                    y_nxt     = Y_W'(START_Y);
                    dx_nxt    = dir_to_delta(dir_x);
                    dy_nxt    = dir_to_delta(dir_y);
                    // A stationary bullet makes no sense; default to straight up.
                    if (dir_to_delta(dir_x) == 2'sd0 && dir_to_delta(dir_y) == 2'sd0) begin
                        dy_nxt = -2'sd1;
                    end
                end
            end
            SLOT_FLYING: begin
                if (hit) begin
                    state_nxt = SLOT_IDLE;
                end else if (tick) begin
                    if (out_of_bounds) begin
                        // Leave the position at its last on-screen value.
                        state_nxt = SLOT_IDLE;
                    end else begin
                        x_nxt = X_W'(nx);
                        y_nxt = Y_W'(ny);
                    end
                end
            end
            default: state_nxt = SLOT_IDLE;
        endcase
    end

    assign active = (state == SLOT_FLYING);

endmodule

// File: rtl/bullet_pool.sv
// Pool of bullet slots with fire cooldown, a free-running movement divider,
// a lowest-index-free allocator and live-count / full flags.
module bullet_pool
    import bullet_pool_pkg::*;
#(
    parameter int NUM_BULLETS   = 8,
    parameter int X_W           = 8,
    parameter int Y_W           = 7,
    parameter int SCREEN_W      = DEF_SCREEN_W,
    parameter int SCREEN_H      = DEF_SCREEN_H,
    parameter int START_X       = DEF_START_X,
    parameter int START_Y       = DEF_START_Y,
    parameter int FIRE_COOLDOWN = 12500000,
    parameter int MOVE_DIV      = 1000000
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             shoot,
    input  logic [1:0]                       dir_x,
    input  logic [1:0]                       dir_y,
    input  logic [NUM_BULLETS-1:0]           hit,
    output logic [NUM_BULLETS-1:0]           active,
    output logic [NUM_BULLETS*X_W-1:0]       bullet_x,
    output logic [NUM_BULLETS*Y_W-1:0]       bullet_y,
    output logic                             fired,
    output logic                             pool_full,
    output logic [$clog2(NUM_BULLETS+1)-1:0] live_count
);

    localparam int CNT_W = $clog2(NUM_BULLETS + 1);
    localparam int CD_W  = (FIRE_COOLDOWN > 0) ? $clog2(FIRE_COOLDOWN + 1) : 1;
    localparam int DIV_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

    localparam logic [CD_W-1:0]  CD_RELOAD = CD_W'(FIRE_COOLDOWN);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(MOVE_DIV - 1);

    logic [CD_W-1:0]        cooldown;
    logic [DIV_W-1:0]       div_cnt;
    logic                   move_tick;
    logic                   shot_ok;
    logic                   alloc_found;
    logic [NUM_BULLETS-1:0] alloc_vec;
    logic [CNT_W-1:0]       live_sum;

    // All decisions use the slot state at the start of the cycle, so a slot
    // freed this cycle only becomes allocatable on the next one.
    assign shot_ok   = shoot && (cooldown == '0) && !pool_full;
    assign move_tick = (div_cnt == DIV_LAST);

    // Cooldown: reload on an accepted shot, otherwise count down to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cooldown <= '0;
        end else if (shot_ok) begin
            cooldown <= CD_RELOAD;
        end else if (cooldown != '0) begin
            cooldown <= cooldown - CD_W'(1);
        end
    end

    // Movement divider: free-running, wraps after MOVE_DIV cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (move_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Fired pulse lines up with the cycle the new slot shows active.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fired <= 1'b0;
        end else begin
            fired <= shot_ok;
        end
    end

    // Priority allocator: grant the accepted shot to the lowest idle slot.
    always_comb begin
        alloc_vec   = '0;
        alloc_found = 1'b0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (!alloc_found && !active[i]) begin
                alloc_vec[i] = shot_ok;
                alloc_found  = 1'b1;
            end
        end
    end

    // Population count of in-flight slots.
    always_comb begin
        live_sum = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            live_sum = live_sum + CNT_W'(active[i]);
        end
    end

    assign live_count = live_sum;
    assign pool_full  = &active;

    for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_slot
        bullet_slot #(
            .X_W      (X_W),
            .Y_W      (Y_W),
            .SCREEN_W (SCREEN_W),
            .SCREEN_H (SCREEN_H),
            .START_X  (START_X),
            .START_Y  (START_Y)
        ) u_slot (
            .clk    (clk),
            .reset  (reset),
            .alloc  (alloc_vec[g]),
            .tick   (move_tick),
            .hit    (hit[g]),
            .dir_x  (dir_x),
            .dir_y  (dir_y),
            .active (active[g]),
            .x      (bullet_x[g*X_W +: X_W]),
            .y      (bullet_y[g*Y_W +: Y_W])
        );
    end

endmodule

// File: doc/bullet_pool.md
BULLET_POOL -- requirements
Module: bullet_pool

Interface
REQ-001 Parameter NUM_BULLETS, default 8, number of bullet slots (1..16).
REQ-002 Parameter X_W, default 8, x-coordinate width.
REQ-003 Parameter Y_W, default 7, y-coordinate width.
REQ-004 Parameter SCREEN_W, default 160, x limit (valid x: 0..SCREEN_W-1).
REQ-005 Parameter SCREEN_H, default 120, y limit (valid y: 0..SCREEN_H-1).
REQ-006 Parameter START_X, default 79; START_Y, default 59; spawn position.
REQ-007 Parameter FIRE_COOLDOWN, default 12500000, minimum cycles between accepted shots.
REQ-008 Parameter MOVE_DIV, default 1000000, cycles per movement step.
REQ-009 clk  in  1  sole clock, rising edge.
REQ-010 reset  in  1  asynchronous, active-high reset.
REQ-011 shoot  in  1  level fire request.
REQ-012 dir_x  in  2  01 = +1, 10 = -1, 00/11 = 0.
REQ-013 dir_y  in  2  same encoding as dir_x.
REQ-014 hit  in  NUM_BULLETS  per-slot collision; frees the slot.
REQ-015 active  out  NUM_BULLETS  slot in flight.
REQ-016 bullet_x  out  NUM_BULLETS*X_W  packed x; slot i at [i*X_W +: X_W].
REQ-017 bullet_y  out  NUM_BULLETS*Y_W  packed y; slot i at [i*Y_W +: Y_W].
REQ-018 fired  out  1  one-cycle pulse on accepted shot.
REQ-019 pool_full  out  1  all slots active.
REQ-020 live_count  out  $clog2(NUM_BULLETS+1)  number of active slots.

Function
REQ-021 Per-slot FSM has two states, IDLE and FLYING; active = FLYING.
REQ-022 Cooldown counter reloads to FIRE_COOLDOWN on an accepted shot and decrements to 0, saturating.
REQ-023 Shot accepted when shoot=1, cooldown=0 and pool_full=0, evaluated on state at the start of the cycle.
REQ-024 Accepted shot allocates the lowest-index IDLE slot: next cycle active=1, x=START_X, y=START_Y, direction latched from dir_x/dir_y; fired pulses the same cycle as the state update.
REQ-025 If the latched direction is (0,0), it is replaced by dy=-1 (upward).
REQ-026 Shot while full or cooling down is dropped, with no queueing; held shoot fires once every FIRE_COOLDOWN+1 cycles.
REQ-027 Move tick: free-running divider pulses every MOVE_DIV cycles; on a tick every FLYING slot adds its latched dx/dy.
REQ-028 A step whose next x is outside 0..SCREEN_W-1 or next y outside 0..SCREEN_H-1 sends the slot to IDLE; coordinates never wrap, and the position holds its last valid value.
REQ-029 hit[i]=1 sends slot i to IDLE next cycle; hit on an IDLE slot is ignored.
REQ-030 Hit and move tick on the same slot in the same cycle: hit wins.
REQ-031 A slot freed this cycle is not allocatable until the following cycle.
REQ-032 A newly allocated slot does not move on an allocation-cycle tick.
REQ-033 live_count and pool_full are combinational from active.

Reset
REQ-034 On reset: all slots IDLE, active=0, bullet_x/bullet_y=0, fired=0, cooldown=0, move divider=0; flight is aborted mid-step.
REQ-035 First shot is accepted on the first cycle after reset deasserts.

Structure
REQ-036 A shared package holds the direction encoding constants and the default screen/spawn constants.
REQ-037 One sub-module, bullet_slot (FSM, position, bounds check), is instantiated NUM_BULLETS times through generate.
REQ-038 The pool owns the cooldown, the divider, the priority allocator and the count.

Verification
REQ-039 Reset, shoot=1, dir=(01,00), FIRE_COOLDOWN=4 -> slot0 at (79,59), fired pulses, next shot fires 5 cycles later into slot1.
REQ-040 MOVE_DIV=2, slot0 dir (+1,0) from x=79 -> x reaches 159, next tick frees slot0 with x holding 159.
REQ-041 Fill all 8 slots -> pool_full=1, live_count=8, ninth shoot produces no fired; hit[3] -> next accepted shot takes slot3.
REQ-042 hit[2] and move tick in the same cycle -> slot2 IDLE, position unchanged.
REQ-043 dir=(00,00) shot -> y decrements each tick from 59 to 0, then the slot frees.
REQ-044 Reset asserted asynchronously mid-flight with 3 slots active -> active=0 immediately, no fired pulse.
